// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the system-ID boot checker.
// States, error codes and Avalon word addresses.
package sysid_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_RD_TS,
      ST_GAP,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ID      = 2'd1;
   localparam logic [1:0] ERR_TS      = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   function automatic logic is_read(state_t s);
      return (s == ST_RD_ID) || (s == ST_RD_TS);
   endfunction

endpackage

// File: rtl/sysid_chk_timer.sv
// Waitrequest stall timer for one read attempt.
// expired fires on the stalled cycle that brings the count to TIMEOUT_CYCLES.
module sysid_chk_timer #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= 8'd0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   // Count includes the current stalled cycle so an attempt lasts exactly
   // TIMEOUT_CYCLES cycles.
   assign expired = enable &&
                    (({1'b0, count} + 9'd1) == {1'b0, TIMEOUT_CYCLES});

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads and checks the system-ID words at boot.
// Per-read stall timeout with bounded retry keeps boot from hanging.
module sysid_boot_checker
   import sysid_chk_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1508264427,
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
   parameter logic [1:0]  MAX_RETRIES    = 2'd3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  error_code,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   state_t     state;
   state_t     nstate;
   logic [1:0] retries;
   logic       in_rd;
   logic       expired;
   logic       start_ok;
   logic       cap_id;
   logic       cap_ts;
   logic       retry_inc;
   logic       to_err;
   logic       do_check;

   assign in_rd = is_read(state);
   assign busy  = (state != ST_IDLE);
   assign done  = (state == ST_DONE);

   sysid_chk_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (!in_rd || !avm_waitrequest),
      .enable (in_rd && avm_waitrequest),
      .expired(expired)
   );

   always_comb begin
      nstate    = state;
      start_ok  = 1'b0;
      cap_id    = 1'b0;
      cap_ts    = 1'b0;
      retry_inc = 1'b0;
      to_err    = 1'b0;
      do_check  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               nstate   = ST_RD_ID;
            end
         end
         ST_RD_ID, ST_RD_TS: begin
            if (!avm_waitrequest) begin
               if (state == ST_RD_ID) begin
                  cap_id = 1'b1;
                  nstate = ST_RD_TS;
               end else begin
                  cap_ts = 1'b1;
                  nstate = ST_CHECK;
               end
            end else if (expired) begin
               if (retries < MAX_RETRIES) begin
                  retry_inc = 1'b1;
                  nstate    = ST_GAP;
               end else begin
                  to_err = 1'b1;
                  nstate = ST_DONE;
               end
            end
         end
         // The held address remembers which word was interrupted.
         ST_GAP: begin
            nstate = (avm_address == ADDR_TS) ? ST_RD_TS : ST_RD_ID;
         end
         ST_CHECK: begin
            do_check = 1'b1;
            nstate   = ST_DONE;
         end
         ST_DONE: begin
            nstate = ST_IDLE;
         end
         default: begin
            nstate = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         avm_read    <= 1'b0;
         avm_address <= ADDR_ID;
         retries     <= 2'd0;
         pass        <= 1'b0;
         error_code  <= ERR_NONE;
         id_value    <= 32'd0;
         ts_value    <= 32'd0;
      end else begin
         state    <= nstate;
         avm_read <= is_read(nstate);
         if (nstate == ST_RD_ID) begin
            avm_address <= ADDR_ID;
         end else if (nstate == ST_RD_TS) begin
            avm_address <= ADDR_TS;
         end
         if (start_ok) begin
            retries    <= 2'd0;
            pass       <= 1'b0;
            error_code <= ERR_NONE;
            id_value   <= 32'd0;
            ts_value   <= 32'd0;
         end
         if (cap_id) begin
            id_value <= avm_readdata;
            retries  <= 2'd0;
         end
         if (cap_ts) begin
            ts_value <= avm_readdata;
         end
         if (retry_inc) begin
            retries <= retries + 2'd1;
         end
         if (to_err) begin
            error_code <= ERR_TIMEOUT;
         end
         if (do_check) begin
            if (id_value != EXPECTED_ID) begin
               error_code <= ERR_ID;
            end else if (ts_value != EXPECTED_TS) begin
               error_code <= ERR_TS;
            end else begin
               pass       <= 1'b1;
               error_code <= ERR_NONE;
            end
         end
      end
   end

endmodule
